// File: rtl/door_pkg.sv
// Shared state encoding and default timing for the entrance door controller.
// No pipeline and no flow control: constants and types only.
package door_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_TRAVEL_CYCLES   = 8;
  localparam int DEF_HOLD_CYCLES     = 16;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    CLOSING = 3'd4
  } door_state_t;

endpackage

// File: rtl/door_debounce.sv
// Two-flop synchroniser plus debounce filter for the floor mat level.
// pressDet follows a clean input change after 2+DEBOUNCE_CYCLES edges; no flow control.
module door_debounce
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pressure,
  output logic pressDet
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      pressDet <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1 <= pressure;
      sync2 <= sync1;
      // Any agreement restarts the run, so only an unbroken mismatch can flip the level.
      if (sync2 == pressDet) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        pressDet <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/door_open.sv
// Door controller: debounced mat drives CLOSED/OPENING/OPEN/HOLD/CLOSING with timed travel and hold.
// Outputs are a Moore decode of the state register (no output stage); no flow control.
module door_open
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TRAVEL_CYCLES   = DEF_TRAVEL_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pressure,
  output logic doorOpen,
  output logic doorClosed,
  output logic motorOpen,
  output logic motorClose
);

  localparam int TW = $clog2(TRAVEL_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLD_CYCLES - 1);

  door_state_t   state;
  logic [TW-1:0] travel_cnt;
  logic [HW-1:0] hold_cnt;
  logic          pressDet;

  door_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .pressure (pressure),
    .pressDet (pressDet)
  );

  // Counters are loaded with N-1 on entry so the phase lasts exactly N edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLOSED;
      travel_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        CLOSED: begin
          if (pressDet) begin
            state      <= OPENING;
            travel_cnt <= TRAVEL_LOAD;
          end
        end
        OPENING: begin
          if (travel_cnt == '0) state <= OPEN;
          else                  travel_cnt <= travel_cnt - TW'(1);
        end
        OPEN: begin
          if (!pressDet) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (pressDet)            state <= OPEN;
          else if (hold_cnt == '0) begin
            state      <= CLOSING;
            travel_cnt <= TRAVEL_LOAD;
          end else                 hold_cnt <= hold_cnt - HW'(1);
        end
        CLOSING: begin
          // A press always wins over expiry so nobody gets caught by the door.
          if (pressDet) begin
            state      <= OPENING;
            travel_cnt <= TRAVEL_LOAD;
          end else if (travel_cnt == '0) state <= CLOSED;
          else                           travel_cnt <= travel_cnt - TW'(1);
        end
        default: state <= CLOSED;
      endcase
    end
  end

  assign doorOpen   = (state == OPEN) || (state == HOLD);
  assign doorClosed = (state == CLOSED);
  assign motorOpen  = (state == OPENING);
  assign motorClose = (state == CLOSING);

endmodule

// File: tb/tb_door_open.sv
// Randomised and directed stimulus for door_open against a timestamp-based behavioural model.
module tb_door_open;

  localparam int D = 4;
  localparam int T = 8;
  localparam int H = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pressure = 1'b0;
  logic doorOpen, doorClosed, motorOpen, motorClose;

  door_open #(
    .DEBOUNCE_CYCLES(D),
    .TRAVEL_CYCLES  (T),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pressure   (pressure),
    .doorOpen   (doorOpen),
    .doorClosed (doorClosed),
    .motorOpen  (motorOpen),
    .motorClose (motorClose)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mat history queue, mismatch run length, and door phase with its start edge.
  localparam int M_SHUT = 10, M_RISE = 11, M_UP = 12, M_LINGER = 13, M_FALL = 14;
  bit hist[$];
  bit m_det;
  int m_run;
  int m_mode;
  int m_since;
  int m_edge = 0;

  function automatic void model_edge(input bit p, input bit r);
    bit seen;
    bit old_det;
    m_edge++;
    if (r) begin
      hist = '{0, 0};
      m_det = 0; m_run = 0; m_mode = M_SHUT; m_since = m_edge;
      return;
    end
    seen    = hist[0];          // level presented after two sampling edges
    old_det = m_det;
    if (seen == m_det) m_run = 0;
    else begin
      m_run++;
      if (m_run == D) begin m_det = seen; m_run = 0; end
    end
    case (m_mode)
      M_SHUT:   if (old_det) begin m_mode = M_RISE; m_since = m_edge; end
      M_RISE:   if (m_edge - m_since == T) m_mode = M_UP;
      M_UP:     if (!old_det) begin m_mode = M_LINGER; m_since = m_edge; end
      M_LINGER: if (old_det) m_mode = M_UP;
                else if (m_edge - m_since == H) begin m_mode = M_FALL; m_since = m_edge; end
      M_FALL:   if (old_det) begin m_mode = M_RISE; m_since = m_edge; end
                else if (m_edge - m_since == T) m_mode = M_SHUT;
      default:  m_mode = M_SHUT;
    endcase
    void'(hist.pop_front());
    hist.push_back(p);
  endfunction

  task automatic step(input bit p, input bit r);
    @(negedge clk);
    pressure = p;
    rst      = r;
    @(posedge clk);
    model_edge(p, r);
    #1;
    check("doorOpen",   int'(doorOpen),   int'(m_mode == M_UP || m_mode == M_LINGER));
    check("doorClosed", int'(doorClosed), int'(m_mode == M_SHUT));
    check("motorOpen",  int'(motorOpen),  int'(m_mode == M_RISE));
    check("motorClose", int'(motorClose), int'(m_mode == M_FALL));
  endtask

  initial begin
    int first_open, first_mo, first_mc, moved, open_seen, onehot_bad;

    // Reset with the mat already occupied.
    step(1, 1);
    step(1, 1);
    check("rst_closed", int'(doorClosed), 1);

    // Open latency from reset release with the mat held.
    first_open = 0; first_mo = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1, 0);
      if (motorOpen && first_mo == 0) first_mo = k;
      if (doorOpen && first_open == 0) first_open = k;
    end
    check("mopen_first_edge", first_mo, 7);
    check("open_first_edge", first_open, 15);

    // Release: pressDet falls 6 edges later, HOLD 16 edges, CLOSING 8 edges.
    first_mc = 0;
    for (int k = 1; k <= 40; k++) begin
      step(0, 0);
      if (motorClose && first_mc == 0) first_mc = k;
    end
    check("close_first_edge", first_mc, 2 + D + 1 + H);
    check("closed_after_cycle", int'(doorClosed), 1);

    // Glitch shorter than the debounce window must not move the door.
    moved = 0;
    for (int k = 0; k < 3; k++) begin step(1, 0); moved |= int'(!doorClosed); end
    for (int k = 0; k < 20; k++) begin step(0, 0); moved |= int'(!doorClosed); end
    check("glitch3_ignored", moved, 0);

    // A pulse exactly the window long is accepted.
    open_seen = 0;
    for (int k = 0; k < 4; k++) begin step(1, 0); open_seen |= int'(doorOpen); end
    for (int k = 0; k < 30; k++) begin step(0, 0); open_seen |= int'(doorOpen); end
    check("glitch4_opens", open_seen, 1);

    // Randomised mat activity with occasional resets.
    onehot_bad = 0;
    for (int burst = 0; burst < 250; burst++) begin
      bit pv = bit'($urandom_range(0, 1));
      bit rv = ($urandom_range(0, 60) == 0);
      int len = (pv || ($urandom_range(0, 2) == 0)) ? $urandom_range(1, 12)
                                                     : $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        step(pv, rv && (k < 2));
        if (int'(doorOpen) + int'(doorClosed) + int'(motorOpen) + int'(motorClose) != 1)
          onehot_bad++;
      end
    end
    check("onehot_outputs", onehot_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/door_open.md
Name: door_open

Overview:
- Automatic store-entrance door controller driven by a floor pressure mat.
- Synchronises and debounces the mat input, drives open/close motor commands through a timed travel phase, and holds the door open for a fixed time after the mat is released.
- Reopens if the mat is pressed while the door is closing.
- Sits between the mat sensor input and the door motor driver / status logic of the smart-store top level.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronised mat level must differ from the current debounced level before the debounced level changes. Legal range ≥1.
- TRAVEL_CYCLES, 8: cycles spent in OPENING or CLOSING. Legal range ≥1.
- HOLD_CYCLES, 16: cycles the door stays open after the mat is released. Legal range ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- pressure  input  1  raw mat level, asynchronous to clk; 1 = occupied.
- doorOpen  output  1  door fully open (states OPEN, HOLD).
- doorClosed  output  1  door fully closed (state CLOSED).
- motorOpen  output  1  drive door toward open (state OPENING).
- motorClose  output  1  drive door toward closed (state CLOSING).

Behaviour:
- Reset, when rst=1 at a clock edge:
  - state becomes CLOSED.
  - both synchroniser flops, debounced level (pressDet) and all counters are cleared to 0.
  - After reset, outputs are doorClosed=1, doorOpen=0, motorOpen=0, motorClose=0.
  - rst takes priority over all other inputs, including in mid-travel.
- Synchroniser: two flops on pressure. sync2 lags pressure by 2 edges.
- Debounce:
  - Counter increments on each edge where sync2 != pressDet.
  - Counter clears on any edge where sync2 == pressDet.
  - On the edge where the mismatch has persisted for DEBOUNCE_CYCLES consecutive edges, pressDet toggles to sync2 and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Outputs are a Moore decode of the state register. There is no extra output register, and exactly one of the four outputs is high in each state.
- State machine (evaluated on each edge, using pressDet):
  - CLOSED: if pressDet=1, go to OPENING and load the travel counter.
  - OPENING: count TRAVEL_CYCLES edges, then go to OPEN. pressDet is ignored.
  - OPEN: stay while pressDet=1. When pressDet=0, go to HOLD and load the hold counter.
  - HOLD:
    - If pressDet=1, go to OPEN. The hold counter is discarded and reloaded on the next entry to HOLD.
    - Otherwise count HOLD_CYCLES edges, then go to CLOSING.
  - CLOSING:
    - If pressDet=1, go to OPENING with a full TRAVEL_CYCLES reload.
    - Otherwise count TRAVEL_CYCLES edges, then go to CLOSED.
- Latency from a clean pressure 0→1 with the door CLOSED:
  - pressDet rises on edge 2+DEBOUNCE_CYCLES.
  - OPENING is entered on the next edge.
  - doorOpen rises after edge 3+DEBOUNCE_CYCLES+TRAVEL_CYCLES. With defaults that is edge 15.
- Latency from a clean pressure 1→0 with the door OPEN:
  - pressDet falls after 2+DEBOUNCE_CYCLES edges.
  - HOLD is entered on the next edge.
  - CLOSING is entered HOLD_CYCLES edges later.
  - CLOSED is reached TRAVEL_CYCLES edges after that.
- Counter widths: $clog2 of the respective parameter + 1. Down-counters must not wrap below 0.
- Simultaneous events:
  - pressDet=1 on the same edge the CLOSING counter expires: reopen wins, next state is OPENING.
  - pressDet=1 on the same edge the HOLD counter expires: stay open, next state is OPEN.
- pressure held constantly high from reset: the door opens and stays OPEN indefinitely.

Decomposition:
- Shared package door_pkg:
  - state enum {CLOSED, OPENING, OPEN, HOLD, CLOSING}, 3-bit encoding.
  - default parameter constants.
- One natural sub-module: door_debounce.
  - Contents: synchroniser plus debounce counter, parameterised by DEBOUNCE_CYCLES.
  - Output: pressDet.
- The FSM and counters remain in door_open.

Test Plan (defaults D=4, T=8, H=16):
- Reset: assert rst for 2 edges with pressure=1 → doorClosed=1, all other outputs 0 during and immediately after reset.
- Open sequence: from reset, pressure=1 held → motorOpen high from edge 7 through edge 14, doorOpen=1 from edge 15 onward, doorClosed=0 from edge 7.
- Full cycle: door OPEN, pressure→0 held → HOLD for 16 edges with doorOpen=1, then motorClose=1 for 8 edges, then doorClosed=1.
- Glitch rejection: door CLOSED, pressure pulse of 3 cycles → all outputs unchanged, doorClosed stays 1. Repeat with a 4-cycle pulse → door opens.
- Reopen in HOLD: pressure drops, then returns after HOLD has run 5 edges → state returns to OPEN, doorOpen never deasserts, hold restarts at the full 16 on the next release.
- Reopen while closing: pressure reasserted mid-CLOSING → motorClose drops and motorOpen rises on the edge after pressDet rises. doorOpen asserts 8 edges later. The expiry/press coincidence on the final CLOSING edge yields OPENING.
